smg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller. It time-multiplexes DIGITS nibbles onto a shared 4-bit digit bus with an active-low one-hot digit select. It supports hex or decimal display, with decimal produced by a sequential binary-to-BCD converter. Values are snapshotted per frame and double-buffered for tear-free display, with optional leading-zero blanking. It sits between the CPU's display register and the segment decoder/pad logic.

---
 rtl/smg_pkg.sv | 16 +
 rtl/smg_bin2bcd.sv | 55 +++++
 rtl/smg_scan_ctrl.sv | 101 ++++++++++
 tb/tb_smg_scan_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg: shared types, constants and helpers for the seven-segment scan controller
package smg_pkg;

    localparam int DIGITS_MAX = 8;

    typedef logic [3:0] bcd_t;

    typedef enum logic {SCAN} scan_state_t;

    localparam bcd_t BLANK_NIB = 4'h0;

    function automatic logic [DIGITS_MAX-1:0] onehot_sel(input logic [$clog2(DIGITS_MAX)-1:0] pos);
        return DIGITS_MAX'(1) << pos;
    endfunction

endpackage

// File: rtl/smg_bin2bcd.sv
// smg_bin2bcd: sequential shift-add-3 binary to BCD converter, one bit per cycle
module smg_bin2bcd
    import smg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = 6
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          start,
    input  logic [DATA_W-1:0]             bin,
    output logic                          busy,
    output logic                          done,
    output logic [4*(BCD_DIGITS-2)-1:0]   bcd,
    output logic                          ovf
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]       sh;
    logic [4*BCD_DIGITS-1:0] acc, adj;
    logic [CW-1:0]           cnt;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        assign adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            sh   <= '0;
            acc  <= '0;
        end else begin
            done <= busy && cnt == CW'(1);
            if (start && !busy) begin
                busy <= 1'b1;
                cnt  <= CW'(DATA_W);
                sh   <= bin;
                acc  <= '0;
            end else if (busy) begin
                acc  <= (adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, sh[DATA_W-1]};
                sh   <= sh << 1;
                cnt  <= cnt - 1'b1;
                busy <= cnt != CW'(1);
            end
        end
    end

    // The two extra top digits only exist to detect values beyond the display range.
    assign bcd = acc[4*BCD_DIGITS-9:0];
    assign ovf = |acc[4*BCD_DIGITS-1 -: 8];

endmodule

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: multiplexed digit scanner with per-frame snapshot, double buffer,
// hex/decimal display and leading-zero blanking
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_TICKS = 50000
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [4*DIGITS-1:0]   Number_Sig,
    input  logic                  Hex_Mode,
    input  logic                  Lz_Blank,
    output logic [3:0]            Number_Data,
    output logic [DIGITS-1:0]     Digit_Sel,
    output logic                  Overflow,
    output logic                  Frame_Tick
);

    localparam int DATA_W = 4 * DIGITS;
    localparam int CW     = $clog2(SCAN_TICKS);
    localparam int IW     = DIGITS > 1 ? $clog2(DIGITS) : 1;

    scan_state_t          state_q, state_d;
    logic [CW-1:0]        c1, c1_d;
    logic [IW-1:0]        idx, idx_d, pos;
    logic                 tc, boundary, lz;
    logic                 cv_start, cv_busy, cv_done, cv_ovf;
    logic [DATA_W-1:0]    cv_bcd;
    bcd_t [DIGITS-1:0]    pend, disp;
    logic                 pend_ovf;
    logic [DIGITS-1:0]    blank, blank_d;

    smg_bin2bcd #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (DIGITS + 2)
    ) u_bin2bcd (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .start (cv_start),
        .bin   (Number_Sig),
        .busy  (cv_busy),
        .done  (cv_done),
        .bcd   (cv_bcd),
        .ovf   (cv_ovf)
    );

    always_comb begin
        state_d  = SCAN;
        tc       = state_q == SCAN && c1 == CW'(SCAN_TICKS - 1);
        boundary = tc && idx == IW'(DIGITS - 1);
        c1_d     = tc ? '0 : c1 + 1'b1;
        idx_d    = !tc ? idx : boundary ? '0 : idx + 1'b1;
        pos      = IW'(DIGITS - 1) - idx;
        cv_start = boundary && !Hex_Mode && !cv_busy;
        // Vectors are indexed by digit weight; blanking runs from the MSD down and stops at the LSD.
        lz       = Lz_Blank;
        blank_d  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz         = lz && pend[k] == 4'h0 && k != 0;
            blank_d[k] = lz;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= SCAN;
            c1          <= '0;
            idx         <= '0;
            pend        <= '0;
            pend_ovf    <= 1'b0;
            disp        <= '0;
            blank       <= '0;
            Overflow    <= 1'b0;
            Frame_Tick  <= 1'b0;
            Number_Data <= BLANK_NIB;
            Digit_Sel   <= '1;
        end else begin
            state_q     <= state_d;
            c1          <= c1_d;
            idx         <= idx_d;
            Frame_Tick  <= boundary;
            Number_Data <= blank[pos] ? BLANK_NIB : disp[pos];
            Digit_Sel   <= blank[pos] ? '1 : ~DIGITS'(onehot_sel(3'(pos)));
            if (boundary) begin
                disp     <= pend;
                blank    <= blank_d;
                Overflow <= pend_ovf;
            end
            // Commit above reads the old pending value; the new snapshot lands afterwards.
            if (boundary && Hex_Mode) begin
                pend     <= Number_Sig;
                pend_ovf <= 1'b0;
            end else if (cv_done) begin
                pend     <= cv_ovf ? {DIGITS{4'h9}} : cv_bcd;
                pend_ovf <= cv_ovf;
            end
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb_smg_scan_ctrl: scoreboard bench; a frame-level model predicts each committed frame,
// a monitor pops it on Frame_Tick and checks every displayed slot.
module tb_smg_scan_ctrl;

    localparam int D = 4;
    localparam int S = 20;
    localparam int F = D * S;

    typedef struct packed {
        logic [D-1:0][3:0] dig;
        logic [D-1:0]      blank;
        logic              ovf;
    } frame_t;

    logic        CLK, RSTn;
    logic [15:0] Number_Sig;
    logic        Hex_Mode, Lz_Blank;
    logic [3:0]  Number_Data;
    logic [3:0]  Digit_Sel;
    logic        Overflow, Frame_Tick;

    logic [3:0]  nd1;
    logic [0:0]  sel1;
    logic        ov1, ft1;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    frame_t pend   = '0;
    frame_t cur    = '0;
    frame_t sb[$];

    smg_scan_ctrl #(.DIGITS(D), .SCAN_TICKS(S)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Number_Sig  (Number_Sig),
        .Hex_Mode    (Hex_Mode),
        .Lz_Blank    (Lz_Blank),
        .Number_Data (Number_Data),
        .Digit_Sel   (Digit_Sel),
        .Overflow    (Overflow),
        .Frame_Tick  (Frame_Tick)
    );

    smg_scan_ctrl #(.DIGITS(1), .SCAN_TICKS(8)) dut1 (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Number_Sig  (4'hC),
        .Hex_Mode    (1'b1),
        .Lz_Blank    (1'b1),
        .Number_Data (nd1),
        .Digit_Sel   (sel1),
        .Overflow    (ov1),
        .Frame_Tick  (ft1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int unsigned pow10(input int unsigned w);
        int unsigned p = 1;
        for (int k = 0; k < int'(w); k++) p = p * 10;
        return p;
    endfunction

    // Pending digits in display order (index 0 = leftmost digit).
    function automatic frame_t snap(input logic [15:0] v, input logic hex);
        frame_t      f = '0;
        int unsigned n = v;
        f.ovf = !hex && n > pow10(D) - 1;
        for (int i = 0; i < D; i++) begin
            if (hex)        f.dig[i] = 4'((n >> (4 * (D - 1 - i))) % 16);
            else if (f.ovf) f.dig[i] = 4'd9;
            else            f.dig[i] = 4'((n / pow10(D - 1 - i)) % 10);
        end
        return f;
    endfunction

    function automatic frame_t commit(input frame_t p, input logic lz);
        frame_t f  = p;
        int     nz = 0;
        while (nz < D - 1 && p.dig[nz] == 4'h0) nz++;
        for (int i = 0; i < D; i++) f.blank[i] = lz && i < nz;
        return f;
    endfunction

    function automatic logic [15:0] rnd_val();
        case ($urandom % 4)
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 9999));
            2:       return 16'($urandom_range(0, 99));
            default: return 16'h0;
        endcase
    endfunction

    // Reference model: every frame boundary commits the pending frame and snapshots the inputs.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cyc  = 0;
            pend = '0;
            sb.delete();
        end else begin
            cyc++;
            if (cyc % F == 0) begin
                sb.push_back(commit(pend, Lz_Blank));
                pend = snap(Number_Sig, Hex_Mode);
            end
        end
    end

    always @(negedge CLK) begin : mon
        int         c, i;
        logic [3:0] sel;
        if (!RSTn) begin
            cur = '0;
            chk("rst_data", Number_Data, 4'h0);
            chk("rst_sel", Digit_Sel, 4'hF);
            chk("rst_ovf", Overflow, 1'b0);
            chk("rst_tick", Frame_Tick, 1'b0);
        end else begin
            c = cyc;
            chk("frame_tick", Frame_Tick, c > 0 && c % F == 0);
            if (c == 0) begin
                chk("first_data", Number_Data, 4'h0);
                chk("first_sel", Digit_Sel, 4'hF);
            end else begin
                i   = ((c - 1) / S) % D;
                sel = 4'b1000;
                sel = ~(sel >> i);
                chk("slot_data", Number_Data, cur.blank[i] ? 4'h0 : cur.dig[i]);
                chk("slot_sel", Digit_Sel, cur.blank[i] ? 4'hF : sel);
            end
            if (Frame_Tick) begin
                chk("frame_avail", sb.size() > 0, 1'b1);
                if (sb.size() > 0) cur = sb.pop_front();
            end
            chk("overflow", Overflow, cur.ovf);
        end
    end

    always @(negedge CLK) begin
        if (RSTn) begin
            chk("d1_tick", ft1, cyc > 0 && cyc % 8 == 0);
            chk("d1_sel", sel1, cyc == 0);
            chk("d1_data", nd1, cyc >= 17 ? 4'hC : 4'h0);
            chk("d1_ovf", ov1, 1'b0);
        end
    end

    initial begin
        RSTn       = 1'b1;
        Number_Sig = '0;
        Hex_Mode   = 1'b1;
        Lz_Blank   = 1'b0;
        #1 RSTn    = 1'b0;
        tick(3);
        RSTn = 1'b1;

        Number_Sig = 16'h1A2F;
        tick(3 * F);

        Hex_Mode   = 1'b0;
        Number_Sig = 16'd1234;
        tick(2 * F);
        Number_Sig = 16'd65535;
        tick(2 * F);

        Lz_Blank   = 1'b1;
        Number_Sig = 16'd7;
        tick(2 * F);
        Number_Sig = 16'd0;
        tick(2 * F);
        Hex_Mode   = 1'b1;
        Number_Sig = 16'h00A0;
        tick(2 * F);

        for (int k = 0; k < 8 * F / 3; k++) begin
            Number_Sig = rnd_val();
            Hex_Mode   = 1'($urandom % 2);
            Lz_Blank   = 1'($urandom % 2);
            tick(3);
        end

        Hex_Mode   = 1'b0;
        Lz_Blank   = 1'b0;
        Number_Sig = 16'd4321;
        for (int k = 0; k < F && cyc % F != 0; k++) tick(1);
        tick(5);
        RSTn = 1'b0;
        tick(3);
        RSTn = 1'b1;
        tick(3 * F);

        tick(2);
        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
